// File: rtl/sweep_sched_if.sv
// Bundle of sweep control, configuration, conversion-engine handshake
// and result signals shared between the sweep scheduler and its environment.
interface sweep_sched_if #(
  parameter int DW = 12,
  parameter int NW = 8
);

  logic          start_i;
  logic          abort_i;
  logic [DW-1:0] cfg_start_i;
  logic [DW-1:0] cfg_step_i;
  logic [NW-1:0] cfg_npts_i;
  logic [1:0]    cfg_avg_i;
  logic          conv_done_i;
  logic [DW-1:0] adc_data_i;

  logic          conv_start_o;
  logic [DW-1:0] dac_code_o;
  logic          res_valid_o;
  logic [DW-1:0] res_code_o;
  logic [DW-1:0] res_data_o;
  logic [NW-1:0] idx_o;
  logic          busy_o;
  logic          done_o;

  // Environment side: drives requests, configuration and conversion results.
  modport master (
    output start_i, abort_i, cfg_start_i, cfg_step_i, cfg_npts_i, cfg_avg_i,
    output conv_done_i, adc_data_i,
    input  conv_start_o, dac_code_o, res_valid_o, res_code_o, res_data_o,
    input  idx_o, busy_o, done_o
  );

  // Scheduler side.
  modport slave (
    input  start_i, abort_i, cfg_start_i, cfg_step_i, cfg_npts_i, cfg_avg_i,
    input  conv_done_i, adc_data_i,
    output conv_start_o, dac_code_o, res_valid_o, res_code_o, res_data_o,
    output idx_o, busy_o, done_o
  );

endinterface

// File: rtl/sweep_sched.sv
// Sweep scheduler: steps a DAC code across a configured number of points,
// issues 2^avg conversions per point, averages the ADC samples and reports
// one result per point. All control outputs are registered.
module sweep_sched #(
  parameter int DW = 12,
  parameter int NW = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  sweep_sched_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    RESULT,
    DONE
  } state_t;

  state_t        state_q;

  logic [DW-1:0] step_q;
  logic [NW-1:0] npts_q;
  logic [1:0]    avg_q;

  logic [DW+2:0] acc_q;
  logic [3:0]    cnt_q;

  logic [DW-1:0] dac_code_q;
  logic [NW-1:0] idx_q;
  logic [DW-1:0] res_code_q;
  logic [DW-1:0] res_data_q;
  logic          conv_start_q;
  logic          res_valid_q;
  logic          done_q;
  logic          busy_q;

  logic [DW+2:0] acc_sum;
  logic [DW+2:0] acc_avg;
  logic [3:0]    cnt_next;
  logic [3:0]    cnt_target;
  logic          last_point;

  // Accumulator update, average, and end-of-point / end-of-sweep decisions.
  always_comb begin
    acc_sum    = acc_q + {3'b000, bus.adc_data_i};
    acc_avg    = acc_sum >> avg_q;
    cnt_next   = cnt_q + 4'd1;
    cnt_target = 4'd1 << avg_q;
    last_point = (idx_q == (npts_q - NW'(1)));
  end

  // Sweep state machine with registered pulse and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      step_q       <= '0;
      npts_q       <= '0;
      avg_q        <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      dac_code_q   <= '0;
      idx_q        <= '0;
      res_code_q   <= '0;
      res_data_q   <= '0;
      conv_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      conv_start_q <= 1'b0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            step_q     <= bus.cfg_step_i;
            npts_q     <= bus.cfg_npts_i;
            avg_q      <= bus.cfg_avg_i;
            dac_code_q <= bus.cfg_start_i;
            idx_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b1;
            if (bus.cfg_npts_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q      <= START;
              conv_start_q <= 1'b1;
            end
          end
        end

        START: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= WAIT;
          end
        end

        WAIT: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (bus.conv_done_i) begin
            acc_q <= acc_sum;
            cnt_q <= cnt_next;
            if (cnt_next == cnt_target) begin
              state_q     <= RESULT;
              res_valid_q <= 1'b1;
              res_data_q  <= acc_avg[DW-1:0];
              res_code_q  <= dac_code_q;
            end else begin
              state_q      <= START;
              conv_start_q <= 1'b1;
            end
          end
        end

        RESULT: begin
          if (bus.abort_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else if (last_point) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q      <= START;
            conv_start_q <= 1'b1;
            idx_q        <= idx_q + NW'(1);
            dac_code_q   <= dac_code_q + step_q;
            acc_q        <= '0;
            cnt_q        <= '0;
          end
        end

        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.conv_start_o = conv_start_q;
  assign bus.dac_code_o   = dac_code_q;
  assign bus.res_valid_o  = res_valid_q;
  assign bus.res_code_o   = res_code_q;
  assign bus.res_data_o   = res_data_q;
  assign bus.idx_o        = idx_q;
  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;

endmodule

// File: tb/tb_sweep_sched.sv
// Directed testbench for sweep_sched: a behavioural conversion engine answers
// each conv_start after a programmable delay, a monitor logs every pulse,
// and each scenario task compares the logs against hand-computed values.
module tb_sweep_sched;

  localparam int DW = 12;
  localparam int NW = 8;

  logic clk_i = 1'b0;
  logic rst_i;

  sweep_sched_if #(.DW(DW), .NW(NW)) bus ();

  sweep_sched #(.DW(DW), .NW(NW)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  int          cd          = 0;
  int          resp_delay  = 5;
  int          conv_num    = 0;
  int          samp_base   = 0;
  int          abort_at    = -1;
  bit          double_mode = 1'b0;
  bit          stray_pend  = 1'b0;
  logic [11:0] samp [16];

  int          n_start   = 0;
  int          n_res     = 0;
  int          n_done    = 0;
  int          n_busy    = 0;
  int          n_overlap = 0;
  logic [11:0] start_log    [256];
  logic [11:0] res_code_log [256];
  logic [11:0] res_data_log [256];

  // Conversion engine model plus output monitor, both on the falling edge.
  always @(negedge clk_i) begin
    bus.conv_done_i = 1'b0;
    bus.abort_i     = 1'b0;
    if (stray_pend) begin
      bus.conv_done_i = 1'b1;
      bus.adc_data_i  = 12'h777;
      stray_pend      = 1'b0;
    end
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        bus.conv_done_i = 1'b1;
        bus.adc_data_i  = samp[(conv_num - samp_base) & 15];
        if (abort_at == conv_num) bus.abort_i = 1'b1;
        conv_num = conv_num + 1;
        if (double_mode) stray_pend = 1'b1;
      end
    end
    if (bus.conv_start_o === 1'b1) begin
      start_log[n_start & 255] = bus.dac_code_o;
      n_start = n_start + 1;
      cd = resp_delay;
    end
    if (bus.res_valid_o === 1'b1) begin
      res_code_log[n_res & 255] = bus.res_code_o;
      res_data_log[n_res & 255] = bus.res_data_o;
      n_res = n_res + 1;
    end
    if (bus.done_o === 1'b1) n_done = n_done + 1;
    if (bus.busy_o === 1'b1) n_busy = n_busy + 1;
    if ((bus.conv_start_o & bus.res_valid_o) | (bus.conv_start_o & bus.done_o) |
        (bus.res_valid_o & bus.done_o))
      n_overlap = n_overlap + 1;
  end

  // Launches a sweep, scrambles cfg and re-pulses start while busy, waits for idle.
  task automatic run_sweep(input logic [11:0] s, input logic [11:0] st,
                           input logic [7:0] n, input logic [1:0] a);
    bit ok;
    @(negedge clk_i);
    bus.cfg_start_i = s;
    bus.cfg_step_i  = st;
    bus.cfg_npts_i  = n;
    bus.cfg_avg_i   = a;
    bus.start_i     = 1'b1;
    @(negedge clk_i);
    bus.start_i     = 1'b0;
    bus.cfg_start_i = 12'hABC;
    bus.cfg_step_i  = 12'h333;
    bus.cfg_npts_i  = 8'd9;
    bus.cfg_avg_i   = 2'd1;
    ok = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.busy_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
      bus.start_i = (c == 2);
      @(negedge clk_i);
    end
    bus.start_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL sweep_timeout: busy_o still %b, required 0", bus.busy_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.conv_start_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_conv_start: got %b want 0", bus.conv_start_o); end
    checks++; if (bus.res_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_res_valid: got %b want 0", bus.res_valid_o); end
    checks++; if (bus.done_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", bus.done_o); end
    checks++; if (bus.dac_code_o !== 12'h000) begin errors++; $display("[TB] FAIL reset_dac_code: got %h want 000", bus.dac_code_o); end
    checks++; if (bus.idx_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_idx: got %h want 00", bus.idx_o); end
    checks++; if (bus.res_code_o !== 12'h000) begin errors++; $display("[TB] FAIL reset_res_code: got %h want 000", bus.res_code_o); end
    checks++; if (bus.res_data_o !== 12'h000) begin errors++; $display("[TB] FAIL reset_res_data: got %h want 000", bus.res_data_o); end
    rst_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_release_busy: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_basic;
    int b_s, b_r, b_d;
    logic [11:0] exp_code [3];
    exp_code[0] = 12'h100; exp_code[1] = 12'h110; exp_code[2] = 12'h120;
    resp_delay = 5;
    samp_base  = conv_num;
    for (int i = 0; i < 16; i++) samp[i] = 12'h0AA;
    b_s = n_start; b_r = n_res; b_d = n_done;
    run_sweep(12'h100, 12'h010, 8'd3, 2'd0);
    checks++; if ((n_start - b_s) !== 3) begin errors++; $display("[TB] FAIL basic_starts: got %0d want 3", n_start - b_s); end
    checks++; if ((n_res - b_r) !== 3) begin errors++; $display("[TB] FAIL basic_results: got %0d want 3", n_res - b_r); end
    checks++; if ((n_done - b_d) !== 1) begin errors++; $display("[TB] FAIL basic_done: got %0d want 1", n_done - b_d); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (start_log[(b_s + i) & 255] !== exp_code[i]) begin errors++; $display("[TB] FAIL basic_code%0d: got %h want %h", i, start_log[(b_s + i) & 255], exp_code[i]); end
      checks++; if (res_code_log[(b_r + i) & 255] !== exp_code[i]) begin errors++; $display("[TB] FAIL basic_res_code%0d: got %h want %h", i, res_code_log[(b_r + i) & 255], exp_code[i]); end
      checks++; if (res_data_log[(b_r + i) & 255] !== 12'h0AA) begin errors++; $display("[TB] FAIL basic_res_data%0d: got %h want 0aa", i, res_data_log[(b_r + i) & 255]); end
    end
    checks++; if (bus.dac_code_o !== 12'h120) begin errors++; $display("[TB] FAIL basic_dac_hold: got %h want 120", bus.dac_code_o); end
  endtask

  task automatic test_average;
    int b_s, b_r, b_d;
    resp_delay = 3;
    samp_base  = conv_num;
    for (int i = 0; i < 16; i++) samp[i] = 12'(i + 1);
    b_s = n_start; b_r = n_res; b_d = n_done;
    run_sweep(12'h200, 12'h001, 8'd1, 2'd3);
    checks++; if ((n_start - b_s) !== 8) begin errors++; $display("[TB] FAIL avg_starts: got %0d want 8", n_start - b_s); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (start_log[(b_s + i) & 255] !== 12'h200) begin errors++; $display("[TB] FAIL avg_code%0d: got %h want 200", i, start_log[(b_s + i) & 255]); end
    end
    checks++; if ((n_res - b_r) !== 1) begin errors++; $display("[TB] FAIL avg_results: got %0d want 1", n_res - b_r); end
    checks++; if (res_data_log[b_r & 255] !== 12'h004) begin errors++; $display("[TB] FAIL avg_res_data: got %h want 004", res_data_log[b_r & 255]); end
    checks++; if (res_code_log[b_r & 255] !== 12'h200) begin errors++; $display("[TB] FAIL avg_res_code: got %h want 200", res_code_log[b_r & 255]); end
    checks++; if ((n_done - b_d) !== 1) begin errors++; $display("[TB] FAIL avg_done: got %0d want 1", n_done - b_d); end
  endtask

  task automatic test_wrap;
    int b_s, b_r;
    resp_delay = 2;
    samp_base  = conv_num;
    samp[0] = 12'h123; samp[1] = 12'h456;
    b_s = n_start; b_r = n_res;
    run_sweep(12'hFF0, 12'h020, 8'd2, 2'd0);
    checks++; if ((n_start - b_s) !== 2) begin errors++; $display("[TB] FAIL wrap_starts: got %0d want 2", n_start - b_s); end
    checks++; if (start_log[b_s & 255] !== 12'hFF0) begin errors++; $display("[TB] FAIL wrap_code0: got %h want ff0", start_log[b_s & 255]); end
    checks++; if (start_log[(b_s + 1) & 255] !== 12'h010) begin errors++; $display("[TB] FAIL wrap_code1: got %h want 010", start_log[(b_s + 1) & 255]); end
    checks++; if (res_code_log[(b_r + 1) & 255] !== 12'h010) begin errors++; $display("[TB] FAIL wrap_res_code1: got %h want 010", res_code_log[(b_r + 1) & 255]); end
    checks++; if (res_data_log[(b_r + 1) & 255] !== 12'h456) begin errors++; $display("[TB] FAIL wrap_res_data1: got %h want 456", res_data_log[(b_r + 1) & 255]); end
  endtask

  task automatic test_empty;
    int b_s, b_r, b_d, b_b;
    b_s = n_start; b_r = n_res; b_d = n_done; b_b = n_busy;
    run_sweep(12'h050, 12'h001, 8'd0, 2'd0);
    checks++; if ((n_busy - b_b) !== 1) begin errors++; $display("[TB] FAIL empty_busy_cycles: got %0d want 1", n_busy - b_b); end
    checks++; if ((n_done - b_d) !== 1) begin errors++; $display("[TB] FAIL empty_done: got %0d want 1", n_done - b_d); end
    checks++; if ((n_start - b_s) !== 0) begin errors++; $display("[TB] FAIL empty_starts: got %0d want 0", n_start - b_s); end
    checks++; if ((n_res - b_r) !== 0) begin errors++; $display("[TB] FAIL empty_results: got %0d want 0", n_res - b_r); end
  endtask

  task automatic test_abort;
    int b_s, b_r, b_d;
    resp_delay = 5;
    samp_base  = conv_num;
    for (int i = 0; i < 16; i++) samp[i] = 12'h055;
    abort_at = conv_num;
    b_s = n_start; b_r = n_res; b_d = n_done;
    run_sweep(12'h100, 12'h010, 8'd4, 2'd0);
    abort_at = -1;
    checks++; if ((n_start - b_s) !== 1) begin errors++; $display("[TB] FAIL abort_starts: got %0d want 1", n_start - b_s); end
    checks++; if ((n_res - b_r) !== 0) begin errors++; $display("[TB] FAIL abort_results: got %0d want 0", n_res - b_r); end
    checks++; if ((n_done - b_d) !== 0) begin errors++; $display("[TB] FAIL abort_done: got %0d want 0", n_done - b_d); end
    samp_base = conv_num;
    b_s = n_start; b_r = n_res; b_d = n_done;
    run_sweep(12'h100, 12'h010, 8'd4, 2'd0);
    checks++; if ((n_start - b_s) !== 4) begin errors++; $display("[TB] FAIL rerun_starts: got %0d want 4", n_start - b_s); end
    checks++; if (start_log[(b_s + 3) & 255] !== 12'h130) begin errors++; $display("[TB] FAIL rerun_code3: got %h want 130", start_log[(b_s + 3) & 255]); end
    checks++; if ((n_res - b_r) !== 4) begin errors++; $display("[TB] FAIL rerun_results: got %0d want 4", n_res - b_r); end
    checks++; if ((n_done - b_d) !== 1) begin errors++; $display("[TB] FAIL rerun_done: got %0d want 1", n_done - b_d); end
  endtask

  task automatic test_reset_mid_sweep;
    int b_s, b_r, b_d;
    bit seen;
    resp_delay = 8;
    samp_base  = conv_num;
    b_s = n_start; b_r = n_res; b_d = n_done;
    @(negedge clk_i);
    bus.cfg_start_i = 12'h0F0;
    bus.cfg_step_i  = 12'h001;
    bus.cfg_npts_i  = 8'd2;
    bus.cfg_avg_i   = 2'd0;
    bus.start_i     = 1'b1;
    @(negedge clk_i);
    bus.start_i = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if ((n_start - b_s) == 1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    checks++; if (!seen) begin errors++; $display("[TB] FAIL midrst_first_start: got %0d starts want 1", n_start - b_s); end
    repeat (2) @(negedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_busy: got %b want 0", bus.busy_o); end
    checks++; if (bus.dac_code_o !== 12'h000) begin errors++; $display("[TB] FAIL midrst_dac_code: got %h want 000", bus.dac_code_o); end
    checks++; if (bus.res_code_o !== 12'h000) begin errors++; $display("[TB] FAIL midrst_res_code: got %h want 000", bus.res_code_o); end
    checks++; if (bus.res_data_o !== 12'h000) begin errors++; $display("[TB] FAIL midrst_res_data: got %h want 000", bus.res_data_o); end
    checks++; if (bus.idx_o !== 8'h00) begin errors++; $display("[TB] FAIL midrst_idx: got %h want 00", bus.idx_o); end
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (15) @(negedge clk_i);
    checks++; if ((n_start - b_s) !== 1) begin errors++; $display("[TB] FAIL midrst_starts: got %0d want 1", n_start - b_s); end
    checks++; if ((n_res - b_r) !== 0) begin errors++; $display("[TB] FAIL midrst_results: got %0d want 0", n_res - b_r); end
    checks++; if ((n_done - b_d) !== 0) begin errors++; $display("[TB] FAIL midrst_done: got %0d want 0", n_done - b_d); end
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("[TB] FAIL midrst_idle: got %b want 0", bus.busy_o); end
  endtask

  task automatic test_stray_events;
    int b_s, b_r, b_d;
    resp_delay  = 4;
    samp_base   = conv_num;
    samp[0] = 12'h011; samp[1] = 12'h022;
    double_mode = 1'b1;
    b_s = n_start; b_r = n_res; b_d = n_done;
    run_sweep(12'h300, 12'h005, 8'd2, 2'd0);
    double_mode = 1'b0;
    checks++; if ((n_start - b_s) !== 2) begin errors++; $display("[TB] FAIL stray_starts: got %0d want 2", n_start - b_s); end
    checks++; if (start_log[(b_s + 1) & 255] !== 12'h305) begin errors++; $display("[TB] FAIL stray_code1: got %h want 305", start_log[(b_s + 1) & 255]); end
    checks++; if ((n_res - b_r) !== 2) begin errors++; $display("[TB] FAIL stray_results: got %0d want 2", n_res - b_r); end
    checks++; if (res_data_log[b_r & 255] !== 12'h011) begin errors++; $display("[TB] FAIL stray_res_data0: got %h want 011", res_data_log[b_r & 255]); end
    checks++; if (res_data_log[(b_r + 1) & 255] !== 12'h022) begin errors++; $display("[TB] FAIL stray_res_data1: got %h want 022", res_data_log[(b_r + 1) & 255]); end
    checks++; if ((n_done - b_d) !== 1) begin errors++; $display("[TB] FAIL stray_done: got %0d want 1", n_done - b_d); end
  endtask

  task automatic test_exclusive;
    checks++; if (n_overlap !== 0) begin errors++; $display("[TB] FAIL pulse_overlap: got %0d cycles want 0", n_overlap); end
  endtask

  initial begin
    rst_i           = 1'b1;
    bus.start_i     = 1'b0;
    bus.cfg_start_i = '0;
    bus.cfg_step_i  = '0;
    bus.cfg_npts_i  = '0;
    bus.cfg_avg_i   = '0;
    for (int i = 0; i < 16; i++) samp[i] = '0;
    test_reset;
    test_basic;
    test_average;
    test_wrap;
    test_empty;
    test_abort;
    test_reset_mid_sweep;
    test_stray_events;
    test_exclusive;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
